// File: rtl/logic_unit_pipe_pkg.sv
// rtl/logic_unit_pipe_pkg.sv - shared opcode encoding for the logic unit and its front end
package logic_unit_pipe_pkg;

    typedef logic [2:0] logic_op_t;

    localparam logic_op_t OP_AND   = 3'd0;
    localparam logic_op_t OP_OR    = 3'd1;
    localparam logic_op_t OP_XOR   = 3'd2;
    localparam logic_op_t OP_NOTA  = 3'd3;
    localparam logic_op_t OP_NAND  = 3'd4;
    localparam logic_op_t OP_NOR   = 3'd5;
    localparam logic_op_t OP_XNOR  = 3'd6;
    localparam logic_op_t OP_PASSB = 3'd7;

endpackage

// File: rtl/logic_alu_comb.sv
// rtl/logic_alu_comb.sv - combinational bitwise ALU with zero/ones/parity flags
module logic_alu_comb
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic_op_t        i_op,
    output logic [WIDTH-1:0] o_res,
    output logic             o_zero,
    output logic             o_ones,
    output logic             o_par
);

    always_comb begin
        o_res = i_b;
        case (i_op)
            OP_AND:   o_res = i_a & i_b;
            OP_OR:    o_res = i_a | i_b;
            OP_XOR:   o_res = i_a ^ i_b;
            OP_NOTA:  o_res = ~i_a;
            OP_NAND:  o_res = ~(i_a & i_b);
            OP_NOR:   o_res = ~(i_a | i_b);
            OP_XNOR:  o_res = ~(i_a ^ i_b);
            OP_PASSB: o_res = i_b;
            default:  o_res = i_b;
        endcase
    end

    assign o_zero = (o_res == '0);
    assign o_ones = &o_res;
    assign o_par  = ^o_res;

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage handshaked logic unit with chaining accumulator and op counter
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic_op_t        in_op,
    input  logic             in_sel_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_par,
    output logic [CNT_W-1:0] op_count
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic_op_t        r_s1_op;
    logic             r_s1_sel_acc;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_res;
    logic             r_s2_zero;
    logic             r_s2_ones;
    logic             r_s2_par;

    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_op_count;

    logic             w_s1_load;
    logic             w_s2_load;
    logic             w_complete;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_ones;
    logic             w_par;

    assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready   = !r_s1_valid || w_s2_load;
    assign w_s1_load  = in_valid && in_ready;
    assign w_complete = r_s2_valid && out_ready;
    assign w_opa      = r_s1_sel_acc ? r_acc : r_s1_a;

    logic_alu_comb #(.WIDTH(WIDTH)) u_alu (
        .i_a    (w_opa),
        .i_b    (r_s1_b),
        .i_op   (r_s1_op),
        .o_res  (w_res),
        .o_zero (w_zero),
        .o_ones (w_ones),
        .o_par  (w_par)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_op      <= OP_AND;
            r_s1_sel_acc <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid   <= 1'b1;
            r_s1_a       <= in_a;
            r_s1_b       <= in_b;
            r_s1_op      <= in_op;
            r_s1_sel_acc <= in_sel_acc;
        end else if (w_s2_load) begin
            r_s1_valid   <= 1'b0;
        end
    end

    // Flag reset values describe an all-zero result so the outputs stay self-consistent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_zero  <= 1'b1;
            r_s2_ones  <= 1'b0;
            r_s2_par   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_res   <= w_res;
            r_s2_zero  <= w_zero;
            r_s2_ones  <= w_ones;
            r_s2_par   <= w_par;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // A clear wins over the chaining update; the beat computed this cycle still saw the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (w_s2_load) begin
            r_acc <= w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_complete && (r_op_count != {CNT_W{1'b1}})) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign out_res   = r_s2_res;
    assign out_zero  = r_s2_zero;
    assign out_ones  = r_s2_ones;
    assign out_par   = r_s2_par;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - randomized scoreboard bench for logic_unit_pipe
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       in_sel_acc = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_res;
    logic       out_zero, out_ones, out_par;
    logic [7:0] op_count;

    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [3:0] s_in_a = '0;
    logic [3:0] s_in_b = '0;
    logic [2:0] s_in_op = '0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b1;
    logic [3:0] s_out_res;
    logic       s_out_zero, s_out_ones, s_out_par;
    logic [1:0] s_op_count;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_log[$];
    logic [7:0] m_acc = '0;
    int         m_cnt = 0;
    int         n_acc = 0;
    int         n_done = 0;
    logic       p_stall = 1'b0;
    logic       rnd_bp = 1'b0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sel_acc(in_sel_acc),
        .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_zero(out_zero), .out_ones(out_ones),
        .out_par(out_par), .op_count(op_count)
    );

    logic_unit_pipe #(.WIDTH(4), .CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op), .in_sel_acc(1'b0),
        .acc_clr(1'b0), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_res(s_out_res), .out_zero(s_out_zero), .out_ones(s_out_ones),
        .out_par(s_out_par), .op_count(s_op_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input int op);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~a;
            4: return ~(a & b);
            5: return ~(a | b);
            6: return ~(a ^ b);
            default: return b;
        endcase
    endfunction

    // Scoreboard: checks at negedge, then advances the model for the coming edge.
    always @(negedge clk) begin
        logic [7:0] r;
        logic [7:0] e;
        if (rst_n) begin
            if (p_stall) chk("hold_valid", out_valid, 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    e = exp_q[0];
                    chk("out_res", out_res, e);
                    chk("out_zero", out_zero, (e == 8'h00));
                    chk("out_ones", out_ones, (e == 8'hFF));
                    chk("out_par", out_par, ^e);
                end
            end
            chk("op_count", op_count, m_cnt);
        end
        p_stall = rst_n && out_valid && !out_ready;
        if (!rst_n) begin
            exp_q.delete();
            m_acc = '0;
            m_cnt = 0;
            n_acc = 0;
            n_done = 0;
        end else begin
            if (out_valid && out_ready && exp_q.size() != 0) begin
                got_log.push_back(out_res);
                void'(exp_q.pop_front());
                n_done++;
                if (m_cnt < 255) m_cnt++;
            end
            if (acc_clr) m_acc = '0;
            if (in_valid && in_ready) begin
                r = ref_op(in_sel_acc ? m_acc : in_a, in_b, int'(in_op));
                m_acc = r;
                exp_q.push_back(r);
                n_acc++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic sel, input logic clr);
        int  k;
        logic took;
        in_a = a; in_b = b; in_op = op; in_sel_acc = sel; acc_clr = clr;
        in_valid = 1'b1;
        k = 0;
        took = 1'b0;
        while (!took && k < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!took) chk("send_timeout", took, 1);
        in_valid = 1'b0;
        acc_clr = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int n;
        logic [3:0] sres[8];
        logic       szero[8];
        logic       sones[8];
        logic [7:0] lit[$];

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_zero", out_zero, 1);
        chk("rst_out_ones", out_ones, 0);
        chk("rst_out_par", out_par, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Narrow instance: flag corners and counter saturation.
        n = 0;
        fork
            begin
                s_in_valid = 1'b1;
                s_in_op = 3'd3; s_in_a = 4'hF; s_in_b = 4'h0; @(posedge clk); #1;
                s_in_op = 3'd6; s_in_a = 4'h6; s_in_b = 4'h6; @(posedge clk); #1;
                s_in_op = 3'd7; s_in_a = 4'h0; s_in_b = 4'h5; @(posedge clk); #1;
                s_in_op = 3'd0; s_in_a = 4'h3; s_in_b = 4'h5; @(posedge clk); #1;
                s_in_op = 3'd1; s_in_a = 4'h8; s_in_b = 4'h1; @(posedge clk); #1;
                s_in_valid = 1'b0;
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (s_out_valid && n < 8) begin
                        sres[n] = s_out_res; szero[n] = s_out_zero; sones[n] = s_out_ones;
                        n++;
                    end
                end
            end
        join
        chk("w4_count_beats", n, 5);
        chk("w4_nota_res", sres[0], 4'h0);
        chk("w4_nota_zero", szero[0], 1);
        chk("w4_xnor_res", sres[1], 4'hF);
        chk("w4_xnor_ones", sones[1], 1);
        chk("w4_passb_res", sres[2], 4'h5);
        chk("w4_and_res", sres[3], 4'h1);
        chk("w4_or_res", sres[4], 4'h9);
        chk("w4_op_count_sat", s_op_count, 2'd3);
        @(posedge clk);
        #1;

        // Single AND beat and its latency.
        send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_not_yet", out_valid, 0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("and_res", out_res, 8'h30);
        chk("and_zero", out_zero, 0);
        chk("and_par", out_par, 0);
        @(negedge clk);
        chk("and_count", op_count, 1);
        @(posedge clk);
        #1;

        // All eight ops back-to-back.
        base = got_log.size();
        for (int i = 0; i < 8; i++) begin
            chk("stream_in_ready", in_ready, 1);
            send(8'hA5, 8'h0F, 3'(i), 1'b0, 1'b0);
        end
        drain();
        lit = '{8'h05, 8'hAF, 8'hAA, 8'h5A, 8'hFA, 8'h50, 8'h55, 8'h0F};
        for (int i = 0; i < 8; i++) chk($sformatf("stream_lit%0d", i), got_log[base + i], lit[i]);

        // Chaining through the accumulator, including a clear during a compute.
        base = got_log.size();
        send(8'h00, 8'h01, 3'd1, 1'b1, 1'b1);
        send(8'h00, 8'hFF, 3'd2, 1'b1, 1'b0);
        send(8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        send(8'h00, 8'hFF, 3'd2, 1'b1, 1'b0);
        send(8'h00, 8'h00, 3'd1, 1'b1, 1'b1);
        drain();
        lit = '{8'h01, 8'hFE, 8'hFE, 8'h01, 8'h00};
        for (int i = 0; i < 5; i++) chk($sformatf("chain_lit%0d", i), got_log[base + i], lit[i]);

        // Backpressure: two accepts, then stall with stable output.
        base = got_log.size();
        out_ready = 1'b0;
        send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
        send(8'hF0, 8'h0F, 3'd1, 1'b0, 1'b0);
        fork
            send(8'hFF, 8'h0F, 3'd2, 1'b0, 1'b0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", in_ready, 0);
                    chk("bp_valid_held", out_valid, 1);
                    chk("bp_res_held", out_res, 8'h30);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_delivered", got_log.size() - base, 3);
        lit = '{8'h30, 8'hFF, 8'hF0};
        for (int i = 0; i < 3; i++) chk($sformatf("bp_lit%0d", i), got_log[base + i], lit[i]);

        // Randomized traffic with random backpressure.
        rnd_bp = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0),
                 (n_acc == n_done) && ($urandom_range(0, 5) == 0));
        end
        rnd_bp = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("rand_sat_count", op_count, 8'hFF);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(8'hA5, 8'h0F, 3'd0, 1'b0, 1'b0);
        send(8'h12, 8'h34, 3'd1, 1'b1, 1'b0);
        base = got_log.size();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", op_count, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_zero", out_zero, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(8'h77, 8'h00, 3'd1, 1'b1, 1'b0);
        send(8'h00, 8'h3C, 3'd2, 1'b1, 1'b0);
        drain();
        chk("mid_rst_delivered", got_log.size() - base, 2);
        chk("mid_rst_acc_zero", got_log[base], 8'h00);
        chk("mid_rst_chain", got_log[base + 1], 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational 4-op logic unit.
- Operand width is generic. The opcode set grows to 8 ops, including inverted forms and a pass-through.
- Operand A can come from an internal accumulator, so results can be chained.
- Valid/ready handshakes on input and output, result flags, and a saturating op counter. Sits between the operand/switch front end and the display/output mux.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode; encoding under Behaviour.
- in_sel_acc  input  1  1 = use accumulator instead of in_a as operand A.
- acc_clr  input  1  clear accumulator to 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_res  output  WIDTH  result.
- out_zero  output  1  out_res == 0.
- out_ones  output  1  out_res is all ones.
- out_par  output  1  XOR-reduce of out_res.
- op_count  output  CNT_W  completed results (out_valid && out_ready), saturating.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NOT A.
  - 4 NAND, 5 NOR, 6 XNOR, 7 PASS B.
  - All ops are bitwise over the full WIDTH; no zero-extension and no carries.
- Stage 1 (S1): operand register holding a, b, op, sel_acc, plus s1_valid.
  - Load when in_valid && in_ready.
- Stage 2 (S2): result register holding res and the three flags, plus s2_valid.
  - out_valid = s2_valid; out_res and flags are driven directly from the S2 registers.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_load (combinational; depends on out_ready).
- Compute happens combinationally from S1 into S2 at s2_load.
  - Operand A = sel_acc ? acc : a.
  - Flags are computed from the same result value.
- Latency and throughput:
  - Accepted beat is presented on out_valid 2 cycles later when not stalled.
  - Sustains 1 beat/cycle while out_ready = 1.
- Accumulator acc (WIDTH bits):
  - Loads the computed result on every s2_load.
  - Back-to-back sel_acc beats therefore chain with no bubbles.
- acc_clr:
  - Forces acc to 0 next cycle.
  - Takes priority over a simultaneous s2_load acc update; the result itself still enters S2.
  - A beat being computed in the same cycle as acc_clr uses the pre-clear acc.
- Stall:
  - While out_valid && !out_ready, S2 contents hold stable.
  - S1 holds once full; in_ready drops after at most 2 accepted beats.
- Output rules:
  - No combinational path from in_* to out_*.
  - out_valid never drops without a handshake.
- op_count:
  - Increments on out_valid && out_ready.
  - Holds at 2^CNT_W-1 (no wrap).
- Reset (rst_n = 0 at a clk edge):
  - Clears s1_valid, s2_valid, acc, op_count, and the S2 result/flag registers.
  - Outputs after reset: out_valid=0, out_res=0, out_zero=1, out_ones=0, out_par=0, op_count=0. in_ready=1 when s1_valid=0.
  - Reset mid-stream discards in-flight beats; no partial output is produced.
- X-safety: opcode is 3 bits, so all encodings are defined.

Decomposition:
- Shared package: opcode localparams (OP_AND..OP_PASSB) and a logic_op_t 3-bit typedef, so the front-end mux and this unit share one encoding.
- One natural sub-module: logic_alu_comb. Purely combinational: (a, b, op) -> (res, zero, ones, par). It is reused by the future display path. Pipeline, handshake, accumulator and counter stay in the top.

Test Plan:
- Reset, then op=AND, a=8'hF0, b=8'h3C, out_ready=1 -> 2 cycles later out_res=8'h30, zero=0, par=0; op_count=1.
- Stream all 8 ops back-to-back with a=8'hA5, b=8'h0F -> results 05, AF, AA, 5A, FA, 50, 55, 0F in order, one per cycle.
- Chaining: acc_clr, then beat op=OR, sel_acc=1, b=8'h01, then beat op=XOR, sel_acc=1, b=8'hFF, no gaps -> results 01, FE; acc=FE.
- Backpressure: out_ready=0 while sending 3 beats -> in_ready falls after 2 accepts and out_res is stable. Release out_ready -> all 3 results delivered in order, none lost or duplicated.
- Boundary, with WIDTH=4 and CNT_W=2:
  - NOT A with a=4'hF -> res=0, zero=1.
  - XNOR with a=b -> ones=1.
  - 5 completions -> op_count saturates at 3.
- Reset mid-stream with 2 beats in flight -> next cycle out_valid=0, op_count=0, acc=0; the next accepted beat produces a correct result.
